// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer: iterative shift-add multiplier that borrows the shared EX-stage ALU for its adds.
// Define MUL_SIGNED_EN for two's-complement operands (magnitude multiply plus a FIX negation state).
module alu_mul_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic [WIDTH-1:0]   src1_i,
   input  logic [WIDTH-1:0]   src2_i,
   output logic               busy_o,
   output logic               done_o,
   output logic [2*WIDTH-1:0] prod_o,
   output logic               alu_req_o,
   input  logic               alu_gnt_i,
   output logic [3:0]         alu_ctrl_o,
   output logic [WIDTH-1:0]   alu_src1_o,
   output logic [WIDTH-1:0]   alu_src2_o,
   input  logic [WIDTH-1:0]   alu_result_i,
   input  logic               alu_cout_i
);
   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX, S_DONE} state_t;
   state_t               r_state, w_next, w_after;
   logic [WIDTH-1:0]     r_mcand, r_hi, r_lo, w_mcand, w_mplier;
   logic [CNT_W-1:0]     r_cnt;
   logic [2*WIDTH-1:0]   r_prod, w_shift;
   logic                 w_last, w_step, w_accept;
`ifdef MUL_SIGNED_EN
   logic                 r_sign;
   assign w_mcand  = src1_i[WIDTH-1] ? -src1_i : src1_i;
   assign w_mplier = src2_i[WIDTH-1] ? -src2_i : src2_i;
   assign w_after  = S_FIX;
`else
   assign w_mcand  = src1_i;
   assign w_mplier = src2_i;
   assign w_after  = S_DONE;
`endif
   assign w_accept = (r_state == S_IDLE) && start_i;
   assign w_step   = (r_state == S_ITER) && alu_gnt_i;
   assign w_last   = r_cnt == CNT_W'(WIDTH-1);
   // carry-out becomes the new top bit while the multiplier shifts out the bottom
   assign w_shift  = {alu_cout_i, alu_result_i, r_lo[WIDTH-1:1]};
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = start_i ? S_ITER : S_IDLE;
         S_ITER:  w_next = (alu_gnt_i && w_last) ? w_after : S_ITER;
         S_FIX:   w_next = S_DONE;
         default: w_next = S_IDLE;
      endcase
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
         r_mcand <= '0;
         r_hi    <= '0;
         r_lo    <= '0;
         r_cnt   <= '0;
         r_prod  <= '0;
`ifdef MUL_SIGNED_EN
         r_sign  <= 1'b0;
`endif
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_mcand <= w_mcand;
            r_lo    <= w_mplier;
            r_hi    <= '0;
            r_cnt   <= '0;
`ifdef MUL_SIGNED_EN
            r_sign  <= src1_i[WIDTH-1] ^ src2_i[WIDTH-1];
`endif
         end
         if (w_step) begin
            {r_hi, r_lo} <= w_shift;
            r_cnt        <= r_cnt + 1'b1;
`ifndef MUL_SIGNED_EN
            if (w_last) r_prod <= w_shift;
`endif
         end
`ifdef MUL_SIGNED_EN
         if (r_state == S_FIX) r_prod <= r_sign ? -{r_hi, r_lo} : {r_hi, r_lo};
`endif
      end
   end
   assign alu_req_o  = r_state == S_ITER;
   assign alu_ctrl_o = alu_req_o ? 4'b0010 : 4'b0000;
   assign alu_src1_o = alu_req_o ? r_hi : '0;
   assign alu_src2_o = (alu_req_o && r_lo[0]) ? r_mcand : '0;
   assign busy_o     = r_state != S_IDLE;
   assign done_o     = r_state == S_DONE;
   assign prod_o     = r_prod;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// tb_alu_mul_sequencer: table vectors plus randomized operands/grants against a plain multiply model.
module tb_alu_mul_sequencer;
   localparam int W = 32;
`ifdef MUL_SIGNED_EN
   localparam int EXTRA = 1;
`else
   localparam int EXTRA = 0;
`endif
   logic clk = 0, rst, start, gnt, busy, done, req, cout;
   logic [W-1:0] src1, src2, asrc1, asrc2, ares;
   logic [2*W-1:0] prod;
   logic [3:0] ctrl;
   logic [W:0] sum;
   int checks = 0, errors = 0;

   always #5 clk = ~clk;
   assign sum  = {1'b0, asrc1} + {1'b0, asrc2};
   assign ares = sum[W-1:0];
   assign cout = sum[W];

   alu_mul_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .src1_i(src1), .src2_i(src2),
      .busy_o(busy), .done_o(done), .prod_o(prod), .alu_req_o(req), .alu_gnt_i(gnt),
      .alu_ctrl_o(ctrl), .alu_src1_o(asrc1), .alu_src2_o(asrc2),
      .alu_result_i(ares), .alu_cout_i(cout));

   typedef struct {
      logic [W-1:0] a, b;
      int mode, ign, rstk;
      logic [2*W-1:0] eu, es;
   } vec_t;
   vec_t tv[9];

   function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MUL_SIGNED_EN
      return $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
`else
      return {{W{1'b0}}, a} * {{W{1'b0}}, b};
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_busy"}, 64'(busy), 0);
      check({tag, "_done"}, 64'(done), 0);
      check({tag, "_prod"}, prod, 0);
      check({tag, "_req"}, 64'(req), 0);
      check({tag, "_ctrl"}, 64'(ctrl), 0);
      check({tag, "_asrc"}, {asrc1, asrc2}, 0);
   endtask

   // mode: 0 grant always, 1 grant on even cycles, 2 random grant
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                         input int ign, input int rstk, input logic [2*W-1:0] exp);
      int ngr = 0, exp_done = -1, got = -1;
      logic g, ctrl_ok = 1, exp_req;
      @(negedge clk);
      start = 1; src1 = a; src2 = b; gnt = 0;
      for (int k = 1; k <= 400 && got < 0; k++) begin
         @(negedge clk);
         start = (k == ign);
         if (k == ign) begin src1 = a ^ 32'h5A5A; src2 = b + 3; end
         g = (mode == 0) ? 1'b1 : (mode == 1) ? (k % 2 == 0) : 1'($urandom_range(0, 1));
         gnt = g;
         if (g && ngr < W) begin
            ngr++;
            if (ngr == W) exp_done = k + 1 + EXTRA;
         end
         if (k == rstk) begin
            rst = 1;
            #1 check_zero("midrst");
            @(negedge clk);
            rst = 0; gnt = 0; start = 0;
            return;
         end
         exp_req = (exp_done < 0) || (k <= exp_done - 1 - EXTRA);
         if (req !== exp_req || ctrl !== (exp_req ? 4'b0010 : 4'b0000)) ctrl_ok = 0;
         if (done) begin
            got = k;
            check("busy_at_done", 64'(busy), 1);
         end
      end
      check("latency", 64'(got), 64'(exp_done));
      check("product", prod, exp);
      check("req_ctrl", 64'(ctrl_ok), 1);
      @(negedge clk);
      start = 0; gnt = 0;
      check("done_pulse", 64'(done), 0);
      check("busy_after", 64'(busy), 0);
      check("prod_held", prod, exp);
   endtask

   initial begin
      tv[0] = '{32'd3, 32'd5, 0, 0, 0, 64'd15, 64'd15};
      tv[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 0, 64'hFFFFFFFE_00000001, 64'd1};
      tv[2] = '{32'd1234, 32'd5678, 1, 0, 0, 64'd7006652, 64'd7006652};
      tv[3] = '{32'd1234, 32'd5678, 0, 10, 0, 64'd7006652, 64'd7006652};
      tv[4] = '{32'd3, 32'd5, 0, 0, 16, 64'd0, 64'd0};
      tv[5] = '{32'd9, 32'd11, 0, 0, 0, 64'd99, 64'd99};
      tv[6] = '{32'hFFFFFFF9, 32'd6, 0, 0, 0, 64'h5_FFFFFFD6, 64'hFFFFFFFF_FFFFFFD6};
      tv[7] = '{32'h80000000, 32'd1, 0, 0, 0, 64'h80000000, 64'hFFFFFFFF_80000000};
      tv[8] = '{32'd0, 32'd12345, 1, 0, 0, 64'd0, 64'd0};
      rst = 1; start = 0; gnt = 0; src1 = 0; src2 = 0;
      @(negedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 0;
      for (int i = 0; i < 9; i++)
`ifdef MUL_SIGNED_EN
         run_op(tv[i].a, tv[i].b, tv[i].mode, tv[i].ign, tv[i].rstk, tv[i].es);
`else
         run_op(tv[i].a, tv[i].b, tv[i].mode, tv[i].ign, tv[i].rstk, tv[i].eu);
`endif
      for (int i = 0; i < 20; i++) begin
         logic [W-1:0] a, b;
         a = $urandom;
         b = $urandom;
         if (i % 5 == 0) a = 32'h80000000;
         if (i % 7 == 0) b = 32'hFFFFFFFF;
         run_op(a, b, 2, 0, 0, model(a, b));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
